// File: rtl/ps_bigreg_collector.sv
// Gathers one PS_BIGREG group from the memory map into a wide register, presents it
// with valid/ready, then clears the group's freshbits so the PS sees it was consumed.
module ps_bigreg_collector #(
  parameter int BASE_ID    = 1,
  parameter int SAMPLES    = 16,
  parameter int DATA_WIDTH = 16,
  parameter int ID_WIDTH   = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [SAMPLES:0]              fresh_bits,
  output logic                          rd_req,
  output logic [ID_WIDTH-1:0]           rd_id,
  input  logic [DATA_WIDTH-1:0]         rd_data,
  output logic [SAMPLES:0]              clr_fresh,
  output logic [SAMPLES*DATA_WIDTH-1:0] data_out,
  output logic                          data_valid,
  input  logic                          data_ready,
  output logic                          err_incomplete
);

  localparam int CW = $clog2(SAMPLES + 1);
  localparam logic [CW-1:0]       LAST_IDX = CW'(SAMPLES - 1);
  localparam logic [CW-1:0]       NUM_REQ  = CW'(SAMPLES);
  localparam logic [ID_WIDTH-1:0] BASE     = ID_WIDTH'(BASE_ID);

  typedef enum logic [1:0] {IDLE, READ, PRESENT, CLEAR} state_t;

  state_t                          state_q, state_d;
  logic [CW-1:0]                   req_cnt_q, req_cnt_d;
  logic [CW-1:0]                   cap_idx_q, cap_idx_d;
  logic                            cap_vld_q, cap_vld_d;
  logic [SAMPLES*DATA_WIDTH-1:0]   data_q, data_d;
  logic                            group_valid;
  logic                            group_complete;

  assign group_valid    = fresh_bits[SAMPLES];
  assign group_complete = &fresh_bits[SAMPLES-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      req_cnt_q <= '0;
      cap_idx_q <= '0;
      cap_vld_q <= 1'b0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      req_cnt_q <= req_cnt_d;
      cap_idx_q <= cap_idx_d;
      cap_vld_q <= cap_vld_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (group_valid) state_d = group_complete ? READ : CLEAR;
      READ:    if (cap_vld_q && (cap_idx_q == LAST_IDX)) state_d = PRESENT;
      PRESENT: if (data_ready) state_d = CLEAR;
      CLEAR:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data returns one cycle after its request, so the word index rides
  // alongside in cap_idx_q and writes land without bubbles.
  always_comb begin
    req_cnt_d = req_cnt_q;
    cap_vld_d = rd_req;
    cap_idx_d = req_cnt_q;
    data_d    = data_q;
    if (rd_req) begin
      req_cnt_d = req_cnt_q + CW'(1);
    end else if (state_q != READ) begin
      req_cnt_d = '0;
    end
    if (cap_vld_q) begin
      data_d[cap_idx_q*DATA_WIDTH +: DATA_WIDTH] = rd_data;
    end
  end

  always_comb begin
    rd_req         = (state_q == READ) && (req_cnt_q != NUM_REQ);
    rd_id          = BASE + ID_WIDTH'(req_cnt_q);
    data_valid     = (state_q == PRESENT);
    clr_fresh      = {(SAMPLES + 1){state_q == CLEAR}};
    err_incomplete = (state_q == IDLE) && group_valid && !group_complete;
  end

  assign data_out = data_q;

endmodule

// File: tb/tb_ps_bigreg_collector.sv
// Bench: a memory-map model serves two collectors (seeds 1/16 and channel mux 30/2);
// expectations come from the group contents and the documented cycle timing.
module tb_ps_bigreg_collector;

  logic clk = 1'b0;
  logic rst;
  logic data_ready;
  always #5 clk = ~clk;

  logic [15:0]  mem [256];
  logic [255:0] fresh_q = '0;
  logic [255:0] set_req;
  logic [255:0] clr_mask;

  logic         req_b, dv_b, err_b, req_s, dv_s, err_s;
  logic [7:0]   id_b, id_s;
  logic [15:0]  rdat_b, rdat_s;
  logic [16:0]  clr_b;
  logic [2:0]   clr_s;
  logic [255:0] dout_b;
  logic [31:0]  dout_s;

  ps_bigreg_collector #(.BASE_ID(1), .SAMPLES(16), .DATA_WIDTH(16), .ID_WIDTH(8)) u_big (
    .clk(clk), .rst(rst), .fresh_bits(fresh_q[17:1]), .rd_req(req_b), .rd_id(id_b),
    .rd_data(rdat_b), .clr_fresh(clr_b), .data_out(dout_b), .data_valid(dv_b),
    .data_ready(data_ready), .err_incomplete(err_b));

  ps_bigreg_collector #(.BASE_ID(30), .SAMPLES(2), .DATA_WIDTH(16), .ID_WIDTH(8)) u_small (
    .clk(clk), .rst(rst), .fresh_bits(fresh_q[32:30]), .rd_req(req_s), .rd_id(id_s),
    .rd_data(rdat_s), .clr_fresh(clr_s), .data_out(dout_s), .data_valid(dv_s),
    .data_ready(data_ready), .err_incomplete(err_s));

  // Memory map: clears win over same-edge sets; read data lags the request by one cycle.
  always_comb begin
    clr_mask = '0;
    clr_mask[17:1]  = clr_b;
    clr_mask[32:30] = clr_s;
  end

  always @(posedge clk) begin
    fresh_q <= (fresh_q | set_req) & ~clr_mask;
    rdat_b  <= req_b ? mem[id_b] : 16'hDEAD;
    rdat_s  <= req_s ? mem[id_s] : 16'hDEAD;
  end

  bit           mon_sel;
  logic         m_req, m_dv, m_err;
  logic [7:0]   m_id;
  logic [16:0]  m_clr;
  logic [255:0] m_dat;
  always_comb begin
    m_req = mon_sel ? req_s : req_b;
    m_dv  = mon_sel ? dv_s : dv_b;
    m_err = mon_sel ? err_s : err_b;
    m_id  = mon_sel ? id_s : id_b;
    m_clr = mon_sel ? {14'h0, clr_s} : clr_b;
    m_dat = mon_sel ? {224'h0, dout_s} : dout_b;
  end

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_w [16];
  logic [15:0] nxt_w [16];

  int           obs_req_cyc[$], obs_req_id[$], dv_cyc[$], clr_cyc[$], err_cyc[$];
  logic [255:0] dv_dat[$];
  logic [16:0]  clr_val[$];

  function automatic logic [255:0] gmask(input bit sel, input int skip);
    logic [255:0] m = '0;
    int base = sel ? 30 : 1;
    int s    = sel ? 2 : 16;
    for (int i = 0; i <= s; i++) if (i != skip) m[base + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [255:0] pack(input int s, input logic [15:0] w [16]);
    logic [255:0] v = '0;
    for (int k = 0; k < s; k++) v[k*16 +: 16] = w[k];
    return v;
  endfunction

  task automatic write_group(input bit sel, input int skip);
    int base = sel ? 30 : 1;
    int s    = sel ? 2 : 16;
    @(negedge clk);
    for (int k = 0; k < s; k++) mem[base + k] = exp_w[k];
    set_req = gmask(sel, skip);
  endtask

  // Cycle 0 is the first IDLE cycle in which a freshly written group is visible.
  task automatic watch(input bit sel, input int ncyc, input int ready_low, input int rearm);
    int dvn = 0;
    mon_sel = sel;
    obs_req_cyc.delete(); obs_req_id.delete(); dv_cyc.delete(); dv_dat.delete();
    clr_cyc.delete(); clr_val.delete(); err_cyc.delete();
    data_ready = (ready_low == 0);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      if (i == 0 || i == rearm + 1) set_req = '0;
      if (m_req) begin obs_req_cyc.push_back(i); obs_req_id.push_back(int'(m_id)); end
      if (m_dv) begin dvn++; dv_cyc.push_back(i); dv_dat.push_back(m_dat); end
      if (m_clr != '0) begin clr_cyc.push_back(i); clr_val.push_back(m_clr); end
      if (m_err) err_cyc.push_back(i);
      if (i == rearm) begin
        for (int k = 0; k < 16; k++) mem[1 + k] = nxt_w[k];
        set_req = gmask(1'b0, -1);
      end
      data_ready = (ready_low == 0) || (dvn > ready_low);
    end
    data_ready = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; data_ready = 1'b1; set_req = '0; mon_sel = 1'b0;
    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    repeat (2) @(negedge clk);
    checks++;
    if ({req_b, dv_b, err_b, clr_b, dout_b} !== '0 || id_b !== 8'd1) begin
      errors++; $display("FAIL reset_big: req=%0b dv=%0b err=%0b clr=%h id=%0d dout=%h, want zeros and id=1",
                         req_b, dv_b, err_b, clr_b, id_b, dout_b);
    end
    checks++;
    if ({req_s, dv_s, err_s, clr_s, dout_s} !== '0 || id_s !== 8'd30) begin
      errors++; $display("FAIL reset_small: req=%0b dv=%0b clr=%h id=%0d dout=%h, want zeros and id=30",
                         req_s, dv_s, clr_s, id_s, dout_s);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic;
    for (int k = 0; k < 16; k++) exp_w[k] = 16'h1000 + 16'(k);
    write_group(1'b0, -1);
    watch(1'b0, 24, 0, -1);
    checks++;
    if (obs_req_cyc.size() != 16) begin errors++; $display("FAIL basic_req_count: got %0d want 16", obs_req_cyc.size()); end
    for (int i = 0; i < obs_req_cyc.size() && i < 16; i++) begin
      checks++;
      if (obs_req_cyc[i] != 1 + i || obs_req_id[i] != 1 + i) begin
        errors++; $display("FAIL basic_rd_id[%0d]: cycle %0d id %0d, want cycle %0d id %0d", i, obs_req_cyc[i], obs_req_id[i], 1 + i, 1 + i);
      end
    end
    checks++;
    if (dv_cyc.size() != 1 || dv_cyc[0] != 18) begin errors++; $display("FAIL basic_valid: %0d valid cycles, first at %0d, want 1 at 18", dv_cyc.size(), dv_cyc.size() ? dv_cyc[0] : -1); end
    checks++;
    if (dv_dat.size() == 0 || dv_dat[0] !== pack(16, exp_w)) begin errors++; $display("FAIL basic_data: got %h want %h", dv_dat.size() ? dv_dat[0] : '0, pack(16, exp_w)); end
    checks++;
    if (clr_cyc.size() != 1 || clr_cyc[0] != 19 || clr_val[0] !== 17'h1FFFF) begin
      errors++; $display("FAIL basic_clear: %0d pulses, first at %0d value %h, want 1 at 19 value 1ffff", clr_cyc.size(), clr_cyc.size() ? clr_cyc[0] : -1, clr_val.size() ? clr_val[0] : '0);
    end
    checks++;
    if (fresh_q[17:1] !== '0 || err_cyc.size() != 0) begin errors++; $display("FAIL basic_fresh_cleared: fresh=%h errs=%0d want 0 0", fresh_q[17:1], err_cyc.size()); end
  endtask

  task automatic test_backpressure;
    for (int k = 0; k < 16; k++) exp_w[k] = 16'($urandom);
    write_group(1'b0, -1);
    watch(1'b0, 30, 5, -1);
    checks++;
    if (dv_cyc.size() != 6 || dv_cyc[0] != 18) begin errors++; $display("FAIL bp_valid: %0d valid cycles from %0d, want 6 from 18", dv_cyc.size(), dv_cyc.size() ? dv_cyc[0] : -1); end
    for (int i = 0; i < dv_dat.size(); i++) begin
      checks++;
      if (dv_dat[i] !== pack(16, exp_w)) begin errors++; $display("FAIL bp_data_hold[%0d]: got %h want %h", i, dv_dat[i], pack(16, exp_w)); end
    end
    checks++;
    if (clr_cyc.size() != 1 || clr_cyc[0] != 24) begin errors++; $display("FAIL bp_clear: %0d pulses, first at %0d, want 1 at 24", clr_cyc.size(), clr_cyc.size() ? clr_cyc[0] : -1); end
  endtask

  task automatic test_incomplete;
    for (int k = 0; k < 16; k++) exp_w[k] = 16'($urandom);
    write_group(1'b0, 15);
    watch(1'b0, 12, 0, -1);
    checks++;
    if (err_cyc.size() != 1 || err_cyc[0] != 0) begin errors++; $display("FAIL inc_err: %0d pulses, first at %0d, want 1 at 0", err_cyc.size(), err_cyc.size() ? err_cyc[0] : -1); end
    checks++;
    if (clr_cyc.size() != 1 || clr_cyc[0] != 1 || clr_val[0] !== 17'h1FFFF) begin
      errors++; $display("FAIL inc_clear: %0d pulses, first at %0d, want 1 at 1 value 1ffff", clr_cyc.size(), clr_cyc.size() ? clr_cyc[0] : -1);
    end
    checks++;
    if (obs_req_cyc.size() != 0 || dv_cyc.size() != 0) begin errors++; $display("FAIL inc_quiet: %0d reqs %0d valid cycles, want 0 0", obs_req_cyc.size(), dv_cyc.size()); end
  endtask

  task automatic test_reset_mid_read;
    bit hit = 1'b0;
    for (int k = 0; k < 16; k++) exp_w[k] = 16'($urandom);
    write_group(1'b0, -1);
    for (int i = 0; i < 40 && !hit; i++) begin
      @(negedge clk);
      set_req = '0;
      if (req_b && id_b == 8'd8) hit = 1'b1;
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL rst_reach_id8: rd_id=8 never seen, want within 40 cycles"); end
    rst = 1'b1;
    #1;
    checks++;
    if ({req_b, dv_b, err_b, clr_b, dout_b} !== '0 || id_b !== 8'd1) begin
      errors++; $display("FAIL rst_async: req=%0b clr=%h id=%0d dout=%h, want 0 0 1 0", req_b, clr_b, id_b, dout_b);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (clr_b !== '0 || fresh_q[17:1] !== 17'h1FFFF) begin errors++; $display("FAIL rst_no_clear: clr=%h fresh=%h want 0 1ffff", clr_b, fresh_q[17:1]); end
    rst = 1'b0;
    watch(1'b0, 24, 0, -1);
    checks++;
    if (obs_req_cyc.size() != 16 || obs_req_cyc[0] != 0 || obs_req_id[0] != 1) begin
      errors++; $display("FAIL rst_reread: %0d reqs, first id %0d, want 16 from id 1", obs_req_cyc.size(), obs_req_id.size() ? obs_req_id[0] : -1);
    end
    checks++;
    if (dv_cyc.size() != 1 || dv_cyc[0] != 17 || dv_dat[0] !== pack(16, exp_w)) begin
      errors++; $display("FAIL rst_reread_data: %0d valid cycles, got %h want %h at 17", dv_cyc.size(), dv_dat.size() ? dv_dat[0] : '0, pack(16, exp_w));
    end
    checks++;
    if (clr_cyc.size() != 1 || clr_cyc[0] != 18) begin errors++; $display("FAIL rst_reread_clear: %0d pulses, want 1 at 18", clr_cyc.size()); end
  endtask

  task automatic test_small;
    exp_w[0] = 16'hBEEF; exp_w[1] = 16'hCAFE;
    write_group(1'b1, -1);
    watch(1'b1, 10, 0, -1);
    checks++;
    if (obs_req_id.size() != 2 || obs_req_id[0] != 30 || obs_req_id[1] != 31 || obs_req_cyc[0] != 1) begin
      errors++; $display("FAIL small_ids: %0d reqs first id %0d, want 30,31 from cycle 1", obs_req_id.size(), obs_req_id.size() ? obs_req_id[0] : -1);
    end
    checks++;
    if (dv_cyc.size() != 1 || dv_cyc[0] != 4 || dv_dat[0][31:0] !== 32'hCAFEBEEF) begin
      errors++; $display("FAIL small_data: %0d valid cycles, got %h, want cafebeef at 4", dv_cyc.size(), dv_dat.size() ? dv_dat[0][31:0] : 32'h0);
    end
    checks++;
    if (clr_cyc.size() != 1 || clr_cyc[0] != 5 || clr_val[0] !== 17'h7) begin errors++; $display("FAIL small_clear: %0d pulses, want 1 at 5 value 7", clr_cyc.size()); end
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 16; k++) begin exp_w[k] = 16'($urandom); nxt_w[k] = 16'($urandom); end
    write_group(1'b0, -1);
    watch(1'b0, 48, 0, 20);
    checks++;
    if (obs_req_cyc.size() != 32 || obs_req_cyc[16] != 22 || obs_req_id[16] != 1 || obs_req_id[31] != 16) begin
      errors++; $display("FAIL b2b_second_read: %0d reqs, second starts cycle %0d, want 32 reqs starting at 22",
                         obs_req_cyc.size(), obs_req_cyc.size() > 16 ? obs_req_cyc[16] : -1);
    end
    checks++;
    if (dv_cyc.size() != 2 || dv_cyc[1] != 39 || dv_dat[0] !== pack(16, exp_w) || dv_dat[1] !== pack(16, nxt_w)) begin
      errors++; $display("FAIL b2b_data: %0d valid cycles, second at %0d, want 2 with matching data, second at 39", dv_cyc.size(), dv_cyc.size() > 1 ? dv_cyc[1] : -1);
    end
    checks++;
    if (clr_cyc.size() != 2 || clr_cyc[0] != 19 || clr_cyc[1] - 21 + 1 != 20) begin
      errors++; $display("FAIL b2b_period: %0d clears, IDLE-to-IDLE %0d, want 2 clears and period 20", clr_cyc.size(), clr_cyc.size() > 1 ? clr_cyc[1] - 20 : -1);
    end
  endtask

  task automatic test_clear_collision;
    for (int k = 0; k < 16; k++) begin exp_w[k] = 16'($urandom); nxt_w[k] = 16'($urandom); end
    write_group(1'b0, -1);
    watch(1'b0, 32, 0, 19);
    checks++;
    if (obs_req_cyc.size() != 16 || clr_cyc.size() != 1 || fresh_q[17:1] !== '0) begin
      errors++; $display("FAIL collision_lost: %0d reqs %0d clears fresh=%h, want 16 1 0", obs_req_cyc.size(), clr_cyc.size(), fresh_q[17:1]);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_incomplete;
    test_reset_mid_read;
    test_small;
    test_back_to_back;
    test_clear_collision;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
